// File: rtl/spi_we_table_writer.sv
// Read-modify-write AVMM master that sets or clears a chunk range in the SPI filter write-enable table.
// Define SPI_WE_TABLE_WRITER_READBACK_EN to read back and compare every written word.
module spi_we_table_writer #(
    parameter int FLASH_ADDRESS_BITS = 26,
    parameter int CHUNK_BITS         = FLASH_ADDRESS_BITS - 14,
    parameter int AVMM_ADDRESS_BITS  = FLASH_ADDRESS_BITS - 19
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [CHUNK_BITS-1:0]        i_cmd_first_chunk,
    input  logic [CHUNK_BITS-1:0]        i_cmd_last_chunk,
    input  logic                         i_cmd_set,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_error,
    output logic [AVMM_ADDRESS_BITS-1:0] o_avmm_address,
    output logic                         o_avmm_read,
    output logic                         o_avmm_write,
    output logic [31:0]                  o_avmm_writedata,
    input  logic [31:0]                  i_avmm_readdata,
    input  logic                         i_avmm_readdatavalid,
    input  logic                         i_avmm_waitrequest
);
    // state       | meaning
    // IDLE        | waiting for a command, o_cmd_ready high
    // RANGE_CHECK | validate range, build the mask of the current word
    // READ        | read strobe for the current word
    // READ_WAIT   | waiting for read data
    // WRITE       | write strobe carrying the merged word
    // VERIFY      | readback strobe (readback build only)
    // VERIFY_WAIT | compare readback data (readback build only)
    // DONE        | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE,
        RANGE_CHECK,
        READ,
        READ_WAIT,
        WRITE,
`ifdef SPI_WE_TABLE_WRITER_READBACK_EN
        VERIFY,
        VERIFY_WAIT,
`endif
        DONE
    } state_t;

    state_t state, state_next;

    logic [CHUNK_BITS-1:0]        first_q, last_q;
    logic                         set_q;
    logic [AVMM_ADDRESS_BITS-1:0] word_q;
    logic [31:0]                  wdata_q;
    logic                         error_q, read_q, write_q;

    logic [4:0]  lo, hi;
    logic [31:0] mask;
    logic        range_bad, at_last;

    always_comb begin
        lo        = (word_q == first_q[CHUNK_BITS-1:5]) ? first_q[4:0] : 5'd0;
        hi        = (word_q == last_q[CHUNK_BITS-1:5])  ? last_q[4:0]  : 5'd31;
        mask      = (32'hFFFF_FFFF << lo) & (32'hFFFF_FFFF >> (5'd31 - hi));
        range_bad = first_q > last_q;
        at_last   = word_q == last_q[CHUNK_BITS-1:5];
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (i_cmd_valid) state_next = RANGE_CHECK;
            RANGE_CHECK: begin
                if (range_bad)                 state_next = DONE;
                else if (mask == 32'hFFFF_FFFF) state_next = WRITE;
                else                            state_next = READ;
            end
            READ:        if (!i_avmm_waitrequest) state_next = READ_WAIT;
            READ_WAIT:   if (i_avmm_readdatavalid) state_next = WRITE;
`ifdef SPI_WE_TABLE_WRITER_READBACK_EN
            WRITE:       if (!i_avmm_waitrequest) state_next = VERIFY;
            VERIFY:      if (!i_avmm_waitrequest) state_next = VERIFY_WAIT;
            VERIFY_WAIT: begin
                if (i_avmm_readdatavalid) begin
                    if (i_avmm_readdata != wdata_q || at_last) state_next = DONE;
                    else                                         state_next = RANGE_CHECK;
                end
            end
`else
            WRITE:       if (!i_avmm_waitrequest) state_next = at_last ? DONE : RANGE_CHECK;
`endif
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Strobes follow the next state so they rise and fall on the same edge as the state change.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            first_q <= '0;
            last_q  <= '0;
            set_q   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            read_q  <= (state_next == READ);
            write_q <= (state_next == WRITE);
`ifdef SPI_WE_TABLE_WRITER_READBACK_EN
            if (state_next == VERIFY) read_q <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        first_q <= i_cmd_first_chunk;
                        last_q  <= i_cmd_last_chunk;
                        set_q   <= i_cmd_set;
                        word_q  <= i_cmd_first_chunk[CHUNK_BITS-1:5];
                        error_q <= 1'b0;
                    end
                end
                RANGE_CHECK: begin
                    if (range_bad)                  error_q <= 1'b1;
                    else if (mask == 32'hFFFF_FFFF) wdata_q <= {32{set_q}};
                end
                READ_WAIT: begin
                    if (i_avmm_readdatavalid)
                        wdata_q <= set_q ? (i_avmm_readdata | mask) : (i_avmm_readdata & ~mask);
                end
`ifdef SPI_WE_TABLE_WRITER_READBACK_EN
                VERIFY_WAIT: begin
                    if (i_avmm_readdatavalid) begin
                        if (i_avmm_readdata != wdata_q) error_q <= 1'b1;
                        else if (!at_last)              word_q  <= word_q + AVMM_ADDRESS_BITS'(1);
                    end
                end
`else
                WRITE: begin
                    if (!i_avmm_waitrequest && !at_last) word_q <= word_q + AVMM_ADDRESS_BITS'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_cmd_ready      = (state == IDLE);
    assign o_busy           = (state != IDLE);
    assign o_done           = (state == DONE);
    assign o_error          = error_q;
    assign o_avmm_address   = word_q;
    assign o_avmm_read      = read_q;
    assign o_avmm_write     = write_q;
    assign o_avmm_writedata = wdata_q;
endmodule

// File: tb/tb_spi_we_table_writer.sv
// Testbench for spi_we_table_writer: AVMM memory slave with stalls and latency, chunk-level reference table.
module tb_spi_we_table_writer;
    localparam int CB = 12;
    localparam int AB = 7;

    logic          clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [CB-1:0] i_cmd_first_chunk = '0;
    logic [CB-1:0] i_cmd_last_chunk = '0;
    logic          i_cmd_set = 1'b0;
    logic          o_busy, o_done, o_error;
    logic [AB-1:0] o_avmm_address;
    logic          o_avmm_read, o_avmm_write;
    logic [31:0]   o_avmm_writedata;
    logic [31:0]   i_avmm_readdata = '0;
    logic          i_avmm_readdatavalid = 1'b0;
    logic          i_avmm_waitrequest = 1'b0;

    spi_we_table_writer dut (
        .clock(clock), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_first_chunk(i_cmd_first_chunk), .i_cmd_last_chunk(i_cmd_last_chunk),
        .i_cmd_set(i_cmd_set), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_avmm_address(o_avmm_address), .o_avmm_read(o_avmm_read), .o_avmm_write(o_avmm_write),
        .o_avmm_writedata(o_avmm_writedata), .i_avmm_readdata(i_avmm_readdata),
        .i_avmm_readdatavalid(i_avmm_readdatavalid), .i_avmm_waitrequest(i_avmm_waitrequest)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [31:0] mem[128];
    logic [31:0] model[128];
    int hold = 0, lat = 1, wr_cnt = 0, rd_cnt = 0;
    bit corrupt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // AVMM memory slave, driven on the falling edge
    bit          stalled = 0, rd_pend = 0;
    int          wait_cnt = 0, rd_cd = 0;
    logic [AB-1:0] rd_addr, s_addr;
    logic [31:0] s_data;
    logic        s_rd, s_wr;
    always @(negedge clock) begin
        if (i_reset) begin
            stalled = 0; rd_pend = 0; wait_cnt = 0;
            i_avmm_waitrequest = 1'b0; i_avmm_readdatavalid = 1'b0;
        end else begin
            if (stalled)
                chk("stable during stall", {o_avmm_read, o_avmm_write, o_avmm_address, o_avmm_writedata[22:0]},
                    {s_rd, s_wr, s_addr, s_data[22:0]});
            if (stalled) chk("stable writedata", o_avmm_writedata, s_data);
            if (o_avmm_read && o_avmm_write) chk("read and write together", 32'd1, 32'd0);
            i_avmm_readdatavalid = 1'b0;
            if (rd_pend) begin
                rd_cd--;
                if (rd_cd == 0) begin
                    i_avmm_readdatavalid = 1'b1;
                    i_avmm_readdata = mem[rd_addr] ^ {31'd0, corrupt};
                    rd_pend = 0;
                end
            end
            if (o_avmm_read || o_avmm_write) begin
                if (wait_cnt < hold) begin
                    i_avmm_waitrequest = 1'b1;
                    wait_cnt++;
                    stalled = 1;
                    s_rd = o_avmm_read; s_wr = o_avmm_write;
                    s_addr = o_avmm_address; s_data = o_avmm_writedata;
                end else begin
                    i_avmm_waitrequest = 1'b0;
                    wait_cnt = 0;
                    stalled = 0;
                    if (o_avmm_write) begin
                        mem[o_avmm_address] = o_avmm_writedata;
                        wr_cnt++;
                    end else begin
                        if (rd_pend) chk("second read outstanding", 32'd1, 32'd0);
                        rd_pend = 1; rd_cd = lat; rd_addr = o_avmm_address;
                        rd_cnt++;
                    end
                end
            end else begin
                i_avmm_waitrequest = 1'b0;
                stalled = 0;
                wait_cnt = 0;
            end
        end
    end

    task automatic issue(input int first, input int last, input bit set);
        @(negedge clock);
        i_cmd_first_chunk = CB'(first);
        i_cmd_last_chunk  = CB'(last);
        i_cmd_set         = set;
        i_cmd_valid       = 1'b1;
        @(negedge clock);
        i_cmd_valid       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int inject);
        bit seen = 0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            @(negedge clock);
            if (o_done) seen = 1;
            if (inject != 0 && cyc == 1 && !seen) begin
                chk({tag, " busy at inject"}, 32'(o_busy), 32'd1);
                i_cmd_first_chunk = CB'(0);
                i_cmd_last_chunk  = CB'(4095);
                i_cmd_set         = ~i_cmd_set;
                i_cmd_valid       = 1'b1;
            end else begin
                i_cmd_valid = 1'b0;
            end
        end
        i_cmd_valid = 1'b0;
        chk({tag, " done seen"}, 32'(seen), 32'd1);
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0, idx = 0;
        for (int w = 0; w < 128; w++)
            if (mem[w] !== model[w]) begin
                if (bad == 0) idx = w;
                bad++;
            end
        chk({tag, " table words differing"}, 32'(bad), 32'd0);
        if (bad != 0) chk({tag, " first bad word"}, mem[idx], model[idx]);
    endtask

    task automatic run_cmd(input string tag, input int first, input int last, input bit set, input int inject);
        int exp_w = 0, exp_r = 0;
        bit exp_err = (first > last);
        if (!exp_err) begin
            for (int c = first; c <= last; c++) model[c >> 5][c & 31] = set;
            for (int w = first >> 5; w <= (last >> 5); w++) begin
                exp_w++;
                if (!(first <= w * 32 && last >= w * 32 + 31)) exp_r++;
`ifdef SPI_WE_TABLE_WRITER_READBACK_EN
                exp_r++;
`endif
            end
        end
        wr_cnt = 0;
        rd_cnt = 0;
        issue(first, last, set);
        chk({tag, " busy/ready/error after accept"}, {29'd0, o_busy, o_cmd_ready, o_error}, 32'b100);
        wait_done(tag, inject);
        chk({tag, " error"}, 32'(o_error), 32'(exp_err));
        chk({tag, " writes"}, 32'(wr_cnt), 32'(exp_w));
        chk({tag, " reads"}, 32'(rd_cnt), 32'(exp_r));
        chk_mem(tag);
        @(negedge clock);
        chk({tag, " done/ready after pulse"}, {30'd0, o_done, o_cmd_ready}, 32'b01);
    endtask

    initial begin
        for (int w = 0; w < 128; w++) begin
            mem[w] = '0;
            model[w] = '0;
        end
        #1;
        chk("reset ready/busy/done/error", {28'd0, o_cmd_ready, o_busy, o_done, o_error}, 32'b1000);
        chk("reset strobes", {30'd0, o_avmm_read, o_avmm_write}, 32'd0);
        chk("reset address", 32'(o_avmm_address), 32'd0);
        chk("reset writedata", o_avmm_writedata, 32'd0);
        repeat (3) @(negedge clock);
        i_reset = 1'b0;

        run_cmd("full word set", 0, 31, 1'b1, 0);
        chk("full word value", mem[0], 32'hFFFF_FFFF);

        mem[1] = 32'hFFFF_FFFF; model[1] = 32'hFFFF_FFFF;
        run_cmd("partial clear", 36, 39, 1'b0, 0);
        chk("partial clear value", mem[1], 32'hFFFF_FF0F);

        for (int w = 0; w < 3; w++) begin mem[w] = '0; model[w] = '0; end
        run_cmd("multi word span", 30, 65, 1'b1, 0);
        chk("span word0", mem[0], 32'hC000_0000);
        chk("span word1", mem[1], 32'hFFFF_FFFF);
        chk("span word2", mem[2], 32'h0000_0003);

        run_cmd("range error", 10, 5, 1'b1, 0);
        repeat (2) @(negedge clock);
        chk("error sticky in idle", 32'(o_error), 32'd1);

        hold = 3;
        run_cmd("busy ignore", 200, 300, 1'b1, 1);
        hold = 5;
        lat = 2;
        run_cmd("waitrequest 5", 500, 700, 1'b0, 0);
        hold = 0;
        lat = 1;
        run_cmd("top word", 4000, 4095, 1'b1, 0);
        run_cmd("top partial", 4070, 4093, 1'b0, 0);

        // reset during the first read wait; nothing has been written yet
        lat = 10;
        wr_cnt = 0;
        rd_cnt = 0;
        issue(100, 105, 1'b1);
        for (int cyc = 0; cyc < 50 && rd_cnt == 0; cyc++) @(negedge clock);
        chk("read issued before reset", 32'(rd_cnt), 32'd1);
        @(negedge clock);
        i_reset = 1'b1;
        @(posedge clock);
        #1;
        chk("strobes after reset", {30'd0, o_avmm_read, o_avmm_write}, 32'd0);
        chk("ready/busy after reset", {30'd0, o_cmd_ready, o_busy}, 32'b10);
        repeat (2) @(negedge clock);
        i_reset = 1'b0;
        chk("no write before reset", 32'(wr_cnt), 32'd0);
        chk_mem("after reset");

`ifdef SPI_WE_TABLE_WRITER_READBACK_EN
        lat = 1;
        for (int w = 0; w < 3; w++) begin mem[w] = '0; model[w] = '0; end
        corrupt = 1;
        wr_cnt = 0;
        rd_cnt = 0;
        issue(0, 95, 1'b1);
        wait_done("readback corrupt", 0);
        corrupt = 0;
        model[0] = 32'hFFFF_FFFF;
        chk("readback error", 32'(o_error), 32'd1);
        chk("readback writes", 32'(wr_cnt), 32'd1);
        chk_mem("readback corrupt");
`endif

        for (int n = 0; n < 24; n++) begin
            int f, l;
            f = $urandom_range(0, 4095);
            l = f + $urandom_range(0, 80);
            if (l > 4095) l = 4095;
            if ($urandom_range(0, 5) == 0) begin int t = f; f = l; l = t; end
            hold = $urandom_range(0, 2);
            lat = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                int w = f >> 5;
                mem[w] = $urandom;
                model[w] = mem[w];
            end
            run_cmd($sformatf("random %0d", n), f, l, 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
